// File: rtl/sprite_loader_pkg.sv
// Types and defaults shared by the sprite loader, its bus interface and its image RAM.
package sprite_loader_pkg;

  typedef logic [11:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO
  } loader_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam rgb_t       BLANK_RGB_DEF = 12'h000;

  // The red nibble comes from the HI byte; the LO byte carries green and blue as-is.
  function automatic rgb_t packRgb(input logic [3:0] rNib, input logic [7:0] gbByte);
    return {rNib, gbByte};
  endfunction

endpackage

// File: rtl/sprite_loader_if.sv
// Byte-stream write side, draw-stage read side and status flags of the sprite loader.
interface sprite_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  import sprite_loader_pkg::*;

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] pixel_addr;
  rgb_t                  rgb_pixel;
  logic                  loaded;
  logic                  load_done;
  logic                  load_err;

  modport master (
    output rx_data,
    output rx_valid,
    output pixel_addr,
    input  rx_ready,
    input  rgb_pixel,
    input  loaded,
    input  load_done,
    input  load_err
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  pixel_addr,
    output rx_ready,
    output rgb_pixel,
    output loaded,
    output load_done,
    output load_err
  );

endinterface

// File: rtl/sprite_loader_ram.sv
// Simple dual-port image RAM: synchronous write, registered read-first read port.
module sprite_ram
  import sprite_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  pclk,
  input  logic                  wrEn_i,
  input  logic [ADDR_WIDTH-1:0] wrAddr_i,
  input  rgb_t                  wrData_i,
  input  logic [ADDR_WIDTH-1:0] rdAddr_i,
  output rgb_t                  rdData_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  rgb_t mem [0:DEPTH-1];
  rgb_t rdData_q;

  // No reset and no read enable so the array and its output register map onto block RAM;
  // a same-address write is not forwarded, so the read sees the old word.
  always_ff @(posedge pclk) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    rdData_q <= mem[rdAddr_i];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/sprite_loader.sv
// Loads a sprite image from a SYNC-prefixed byte stream (HI/LO byte per pixel) into RAM
// and serves 1-cycle-latency pixel reads, blanked until a complete image is resident.
module sprite_loader
  import sprite_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter logic [19:0] TIMEOUT    = 20'd650000,
  parameter rgb_t        BLANK_RGB  = BLANK_RGB_DEF
) (
  input logic             pclk,
  input logic             rst,
  sprite_loader_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 20'd1);

  loader_state_e         state_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [ADDR_WIDTH-1:0] wrAddr_d;
  logic [3:0]            rNib_q;
  logic [TW-1:0]         timer_q;
  logic [TW-1:0]         timer_d;
  logic                  rxReady_q;
  logic                  loaded_q;
  logic                  loadDone_q;
  logic                  loadErr_q;
  logic                  showPix_q;

  logic                  accept;
  logic                  wrEn;
  rgb_t                  wrData;
  rgb_t                  ramRdata;

  assign accept   = bus.rx_valid && rxReady_q;
  assign wrAddr_d = wrAddr_q + 1'b1;
  assign timer_d  = timer_q + 1'b1;
  assign wrEn     = accept && (state_q == LO);
  assign wrData   = packRgb(rNib_q, bus.rx_data);

  // Load FSM with its inter-byte watchdog; showPix_q captures loaded on the same edge the
  // RAM samples pixel_addr so blanking lines up with the read data.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q    <= IDLE;
      wrAddr_q   <= '0;
      rNib_q     <= '0;
      timer_q    <= '0;
      rxReady_q  <= 1'b0;
      loaded_q   <= 1'b0;
      loadDone_q <= 1'b0;
      loadErr_q  <= 1'b0;
      showPix_q  <= 1'b0;
    end else begin
      rxReady_q  <= 1'b1;
      loadDone_q <= 1'b0;
      loadErr_q  <= 1'b0;
      showPix_q  <= loaded_q;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (accept && (bus.rx_data == SYNC_BYTE)) begin
            state_q  <= HI;
            loaded_q <= 1'b0;
            wrAddr_q <= '0;
          end
        end
        HI: begin
          if (accept) begin
            rNib_q  <= bus.rx_data[3:0];
            timer_q <= '0;
            state_q <= LO;
          end else if (timer_q == TIMER_LAST) begin
            timer_q   <= '0;
            loadErr_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        LO: begin
          if (accept) begin
            timer_q  <= '0;
            wrAddr_q <= wrAddr_d;
            if (wrAddr_q == '1) begin
              loaded_q   <= 1'b1;
              loadDone_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              state_q <= HI;
            end
          end else if (timer_q == TIMER_LAST) begin
            timer_q   <= '0;
            loadErr_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  sprite_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .pclk     (pclk),
    .wrEn_i   (wrEn),
    .wrAddr_i (wrAddr_q),
    .wrData_i (wrData),
    .rdAddr_i (bus.pixel_addr),
    .rdData_o (ramRdata)
  );

  assign bus.rx_ready  = rxReady_q;
  assign bus.rgb_pixel = showPix_q ? ramRdata : BLANK_RGB;
  assign bus.loaded    = loaded_q;
  assign bus.load_done = loadDone_q;
  assign bus.load_err  = loadErr_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader on a 16-pixel image with an 8-cycle watchdog.
module tb_sprite_loader;
  import sprite_loader_pkg::*;

  localparam int          AW     = 4;
  localparam int          DEPTH  = 16;
  localparam int          TMO_I  = 8;
  localparam logic [19:0] TMO    = 20'd8;
  localparam rgb_t        BLANK  = 12'h000;

  logic pclk = 1'b0;
  logic rst  = 1'b1;

  int   checks  = 0;
  int   errors  = 0;
  int   doneCnt = 0;
  int   errCnt  = 0;

  rgb_t img [DEPTH];
  bit   modelLoaded = 1'b0;
  rgb_t expQ [$];

  sprite_loader_if #(.ADDR_WIDTH(AW)) bus ();

  sprite_loader #(
    .ADDR_WIDTH (AW),
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT    (TMO),
    .BLANK_RGB  (BLANK)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  // Pulse counters sampled mid-cycle so each 1-cycle pulse is seen exactly once.
  always @(negedge pclk) begin
    if (bus.load_done === 1'b1) doneCnt++;
    if (bus.load_err === 1'b1) errCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic checkReset(input string pfx);
    checkOutput({pfx, "_rx_ready"}, bus.rx_ready, 0);
    checkOutput({pfx, "_rgb"}, bus.rgb_pixel, 0);
    checkOutput({pfx, "_loaded"}, bus.loaded, 0);
    checkOutput({pfx, "_done"}, bus.load_done, 0);
    checkOutput({pfx, "_err"}, bus.load_err, 0);
    checkOutput({pfx, "_state"}, dut.state_q, IDLE);
  endtask

  // Expected pixels are pushed when the address is driven and popped once the read returns.
  task automatic readRange(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) begin
      bus.pixel_addr = 4'(n);
      expQ.push_back(modelLoaded ? img[n] : BLANK);
      tick();
      checkOutput($sformatf("rd%0d", n), bus.rgb_pixel, expQ.pop_front());
    end
  endtask

  // Full image load: pixel n is HI={seed, n^seed}, LO={5^seed, A^seed}; seed 0 gives {0n,5A}.
  task automatic applyStimulus(input logic [3:0] seed, input bit withGaps);
    int   k    = 0;
    int   d0   = doneCnt;
    int   e0   = errCnt;
    bit   was  = modelLoaded;
    rgb_t old5 = img[5];
    rgb_t nv;
    bus.pixel_addr = 4'd5;
    sendByte(8'hA5);
    modelLoaded = 1'b0;
    checkOutput("sync_loaded", bus.loaded, 0);
    for (int n = 0; n < DEPTH; n++) begin
      if (withGaps) begin
        idle(k % (TMO_I - 1));
        k++;
      end
      sendByte({seed, 4'(n) ^ seed});
      if (was && n == 0) checkOutput("reload_blank", bus.rgb_pixel, BLANK);
      if (withGaps) begin
        idle(k % (TMO_I - 1));
        k++;
      end
      sendByte({4'h5 ^ seed, 4'hA ^ seed});
      nv = {4'(n) ^ seed, 4'h5 ^ seed, 4'hA ^ seed};
      if (n == 5 && was) begin
        checkOutput("coll_old", dut.ramRdata, old5);
        idle(1);
        checkOutput("coll_new", dut.ramRdata, nv);
      end
      img[n] = nv;
    end
    checkOutput("done_pulse", bus.load_done, 1);
    checkOutput("loaded_set", bus.loaded, 1);
    modelLoaded = 1'b1;
    idle(1);
    checkOutput("done_once", doneCnt - d0, 1);
    checkOutput("no_err", errCnt - e0, 0);
  endtask

  initial begin
    int  d0;
    int  e0;
    int  waited;
    bit  fired;

    bus.rx_data    = 8'h00;
    bus.rx_valid   = 1'b0;
    bus.pixel_addr = '0;
    foreach (img[i]) img[i] = 12'h000;

    rst = 1'b1;
    idle(3);
    checkReset("rst");
    rst = 1'b0;
    idle(1);
    checkOutput("rdy_after_rst", bus.rx_ready, 1);
    readRange(0, 3);

    sendByte(8'h00);
    sendByte(8'hFF);
    sendByte(8'h3C);
    idle(2);
    checkOutput("garbage_state", dut.state_q, IDLE);
    checkOutput("garbage_loaded", bus.loaded, 0);
    applyStimulus(4'h0, 1'b0);
    readRange(0, DEPTH - 1);

    applyStimulus(4'h3, 1'b1);
    readRange(0, DEPTH - 1);
    applyStimulus(4'hF, 1'b0);
    readRange(0, DEPTH - 1);

    sendByte(8'hA5);
    modelLoaded = 1'b0;
    sendByte(8'h01);
    e0     = errCnt;
    waited = 0;
    fired  = 1'b0;
    for (int i = 1; i <= 20 && !fired; i++) begin
      tick();
      if (bus.load_err === 1'b1) begin
        fired  = 1'b1;
        waited = i;
      end
    end
    checkOutput("tmo_latency", waited, TMO_I);
    checkOutput("tmo_loaded", bus.loaded, 0);
    checkOutput("tmo_state", dut.state_q, IDLE);
    idle(1);
    checkOutput("tmo_err_once", errCnt - e0, 1);
    readRange(0, 1);
    applyStimulus(4'h6, 1'b0);
    readRange(0, DEPTH - 1);

    sendByte(8'hA5);
    modelLoaded = 1'b0;
    sendByte(8'h12);
    sendByte(8'h34);
    rst = 1'b1;
    idle(1);
    checkReset("midrst");
    rst = 1'b0;
    idle(1);
    d0 = doneCnt;
    for (int n = 0; n < DEPTH; n++) begin
      sendByte({4'h0, 4'(n)});
      sendByte(8'h5A);
    end
    idle(1);
    checkOutput("nosync_done", doneCnt - d0, 0);
    checkOutput("nosync_loaded", bus.loaded, 0);
    checkOutput("nosync_state", dut.state_q, IDLE);
    applyStimulus(4'h9, 1'b0);
    readRange(0, DEPTH - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
